// File: rtl/rfid_wb_spi_slave.sv
// Wishbone-slave SPI master for the RFID front end; LOOP bit exists only with RFID_SPI_LOOPBACK_EN.
// Bus ack one cycle after strobe with no wait states; TXDATA writes while busy are dropped and raise OVR.
module rfid_wb_spi_slave (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic [2:0] adr_i,
    input  logic       we_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       inta_o,
    output logic       sclk_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output logic [1:0] cs_n_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_TRAIL} state_t;

`ifdef RFID_SPI_LOOPBACK_EN
    localparam logic [7:0] CTRL_MASK = 8'h7B;
`else
    localparam logic [7:0] CTRL_MASK = 8'h3B;
`endif

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [3:0] half_q, half_d;
    logic [7:0] ctrl_q, ctrl_d, div_q, div_d, div_lat_q, div_lat_d;
    logic [7:0] tx_q, tx_d, rxsh_q, rxsh_d, rx_q, rx_d, dat_q, dat_d;
    logic [1:0] cs_lat_q, cs_lat_d;
    logic       cpol_lat_q, cpol_lat_d, done_q, done_d, ovr_q, ovr_d;
    logic       ack_q, ack_d, inta_q, inta_d;
    logic       req, wr, rd, busy, tick, sin;
    logic [7:0] rdata;

    assign busy = (state_q != ST_IDLE);
    assign tick = (cnt_q == {1'b0, div_lat_q});

`ifdef RFID_SPI_LOOPBACK_EN
    assign sin = ctrl_q[6] ? tx_q[7] : miso_i;
`else
    assign sin = miso_i;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        ctrl_d     = ctrl_q;
        div_d      = div_q;
        div_lat_d  = div_lat_q;
        tx_d       = tx_q;
        rxsh_d     = rxsh_q;
        rx_d       = rx_q;
        cs_lat_d   = cs_lat_q;
        cpol_lat_d = cpol_lat_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        req        = cyc_i & stb_i & ~ack_q;
        wr         = req & we_i;
        rd         = req & ~we_i;

        case (adr_i)
            3'd0:    rdata = ctrl_q;
            3'd1:    rdata = div_q;
            3'd3:    rdata = rx_q;
            3'd4:    rdata = {5'b0, ovr_q, done_q, busy};
            default: rdata = 8'h00;
        endcase
        ack_d = req;
        dat_d = rd ? rdata : 8'h00;

        if (wr) begin
            case (adr_i)
                3'd0: ctrl_d = dat_i & CTRL_MASK;
                3'd1: div_d  = dat_i;
                3'd2: begin
                    if (busy) begin
                        ovr_d = 1'b1;
                    end else if (ctrl_q[0]) begin
                        state_d    = ST_LEAD;
                        cnt_d      = 9'd0;
                        half_d     = 4'd0;
                        tx_d       = dat_i;
                        div_lat_d  = div_q;
                        cpol_lat_d = ctrl_q[1];
                        cs_lat_d   = ctrl_q[5:4];
                    end
                end
                3'd4: begin
                    if (dat_i[1]) done_d = 1'b0;
                    if (dat_i[2]) ovr_d  = 1'b0;
                end
                default: ;
            endcase
        end
        if (rd && adr_i == 3'd3) done_d = 1'b0;

        // Even half-periods are sclk-high: entering one samples MISO, entering an odd one shifts MOSI.
        if (busy) begin
            cnt_d = tick ? 9'd0 : cnt_q + 9'd1;
            if (tick) begin
                case (state_q)
                    ST_LEAD: begin
                        state_d = ST_SHIFT;
                        half_d  = 4'd0;
                        rxsh_d  = {rxsh_q[6:0], sin};
                    end
                    ST_SHIFT: begin
                        if (half_q == 4'd15) begin
                            state_d = ST_TRAIL;
                        end else begin
                            half_d = half_q + 4'd1;
                            if (!half_q[0]) tx_d   = {tx_q[6:0], 1'b0};
                            else            rxsh_d = {rxsh_q[6:0], sin};
                        end
                    end
                    ST_TRAIL: begin
                        state_d = ST_IDLE;
                        rx_d    = rxsh_q;
                        done_d  = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
        inta_d = ctrl_d[3] & done_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 9'd0;
            half_q     <= 4'd0;
            ctrl_q     <= 8'h00;
            div_q      <= 8'h00;
            div_lat_q  <= 8'h00;
            tx_q       <= 8'h00;
            rxsh_q     <= 8'h00;
            rx_q       <= 8'h00;
            dat_q      <= 8'h00;
            cs_lat_q   <= 2'b00;
            cpol_lat_q <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ack_q      <= 1'b0;
            inta_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            div_lat_q  <= div_lat_d;
            tx_q       <= tx_d;
            rxsh_q     <= rxsh_d;
            rx_q       <= rx_d;
            dat_q      <= dat_d;
            cs_lat_q   <= cs_lat_d;
            cpol_lat_q <= cpol_lat_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            ack_q      <= ack_d;
            inta_q     <= inta_d;
        end
    end

    assign ack_o  = ack_q;
    assign dat_o  = dat_q;
    assign inta_o = inta_q;
    assign mosi_o = tx_q[7];
    assign cs_n_o = busy ? ~cs_lat_q : 2'b11;
    assign sclk_o = (busy ? cpol_lat_q : ctrl_q[1]) ^ (state_q == ST_SHIFT && !half_q[0]);

endmodule

// File: tb/tb_rfid_wb_spi_slave.sv
// Bench for rfid_wb_spi_slave: transaction-level model checked every cycle plus directed literal checks.
module tb_rfid_wb_spi_slave;

    logic       clk_i = 1'b0, rst_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, miso_i = 1'b0;
    logic [2:0] adr_i = 3'd0;
    logic [7:0] dat_i = 8'h00;
    logic [7:0] dat_o;
    logic       ack_o, inta_o, sclk_o, mosi_o;
    logic [1:0] cs_n_o;

    rfid_wb_spi_slave dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .adr_i(adr_i),
        .we_i(we_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .inta_o(inta_o),
        .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i), .cs_n_o(cs_n_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef RFID_SPI_LOOPBACK_EN
    localparam logic [7:0] MMASK = 8'h7B;
`else
    localparam logic [7:0] MMASK = 8'h3B;
`endif

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: register file plus a transfer timeline measured in elapsed clocks.
    bit         m_ok = 0, m_ack = 0, m_inta = 0, m_busy = 0, m_done = 0, m_ovr = 0, m_cpol = 0;
    logic [7:0] m_dat = 0, m_ctrl = 0, m_div = 0, m_rx = 0, m_tx = 0, miso_byte = 0;
    logic [1:0] m_cs = 0;
    int         m_t = 0, m_H = 1;

    always @(posedge clk_i) begin : model
        logic [7:0] rv;
        bit req, was_busy;
        m_ok = 1;
        if (!rst_i) begin
            m_ack = 0; m_inta = 0; m_busy = 0; m_done = 0; m_ovr = 0; m_cpol = 0;
            m_dat = 0; m_ctrl = 0; m_div = 0; m_rx = 0; m_tx = 0; m_cs = 0; m_t = 0; m_H = 1;
        end else begin
            req = cyc_i && stb_i && !m_ack;
            was_busy = m_busy;
            case (adr_i)
                3'd0:    rv = m_ctrl;
                3'd1:    rv = m_div;
                3'd3:    rv = m_rx;
                3'd4:    rv = {5'b0, m_ovr, m_done, m_busy};
                default: rv = 8'h00;
            endcase
            m_ack = req;
            m_dat = (req && !we_i) ? rv : 8'h00;
            if (req && we_i) begin
                if (adr_i == 3'd0) m_ctrl = dat_i & MMASK;
                if (adr_i == 3'd1) m_div = dat_i;
                if (adr_i == 3'd2) begin
                    if (was_busy) m_ovr = 1;
                    else if (m_ctrl[0]) begin
                        m_busy = 1; m_t = 0; m_H = int'(m_div) + 1;
                        m_tx = dat_i; m_cpol = m_ctrl[1]; m_cs = m_ctrl[5:4];
                    end
                end
                if (adr_i == 3'd4) begin
                    if (dat_i[1]) m_done = 0;
                    if (dat_i[2]) m_ovr = 0;
                end
            end
            if (req && !we_i && adr_i == 3'd3) m_done = 0;
            if (was_busy) begin
                m_t++;
                if (m_t == 18 * m_H) begin
                    m_busy = 0;
                    m_done = 1;
                    m_rx = m_ctrl[6] ? m_tx : miso_byte;
                end
            end
            m_inta = m_ctrl[3] && m_done;
        end
    end

    // Slave side: bit k of miso_byte is presented through phases 2k and 2k+1.
    always @(negedge clk_i) begin : miso_drv
        int k;
        k = m_busy ? (m_t / m_H) / 2 : 8;
        miso_i = (k < 8) ? miso_byte[7 - k] : 1'b0;
    end

    always @(negedge clk_i) begin : compare
        int p;
        logic e_sclk, e_mosi;
        logic [1:0] e_cs;
        if (m_ok) begin
            p = m_busy ? m_t / m_H : 0;
            e_cs   = m_busy ? ~m_cs : 2'b11;
            e_sclk = (m_busy ? m_cpol : m_ctrl[1]) ^ (m_busy && p >= 1 && p <= 16 && (p % 2) == 1);
            e_mosi = (m_busy && p / 2 < 8) ? m_tx[7 - p / 2] : 1'b0;
            chk("ack_o", ack_o, m_ack);
            chk("dat_o", dat_o, m_dat);
            chk("inta_o", inta_o, m_inta);
            chk("cs_n_o", cs_n_o, e_cs);
            chk("sclk_o", sclk_o, e_sclk);
            chk("mosi_o", mosi_o, e_mosi);
        end
    end

    int         cs_run = 0, last_cs = 0, hi_run = 0, last_hi = 0;
    logic [7:0] mosi_cap = 0;
    logic       prev_sclk = 0;
    always @(negedge clk_i) begin : monitor
        if (cs_n_o != 2'b11) cs_run++;
        else begin
            if (cs_run != 0) last_cs = cs_run;
            cs_run = 0;
        end
        if (sclk_o) begin
            if (!prev_sclk) mosi_cap = {mosi_cap[6:0], mosi_o};
            hi_run++;
        end else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0;
        end
        prev_sclk = sclk_o;
    end

    task automatic bus(input logic w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] r);
        cyc_i = 1; stb_i = 1; we_i = w; adr_i = a; dat_i = d;
        @(negedge clk_i);
        chk("bus_ack", ack_o, 1);
        r = dat_o;
        cyc_i = 0; stb_i = 0; we_i = 0; dat_i = 0;
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic rdchk(input logic [2:0] a, input logic [7:0] exp, input string name);
        logic [7:0] r;
        bus(1'b0, a, 8'h00, r);
        chk(name, r, exp);
    endtask

    initial begin : watchdog
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stim
        repeat (3) @(negedge clk_i);
        chk("rst_cs", cs_n_o, 2'b11);
        chk("rst_sclk", sclk_o, 0);
        chk("rst_mosi", mosi_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_inta", inta_o, 0);
        chk("rst_dat", dat_o, 8'h00);
        rst_i = 1;
        for (int a = 0; a < 8; a++) rdchk(3'(a), 8'h00, "reset_read");
        chk("idle_cs", cs_n_o, 2'b11);

        wr(0, 8'hFE);
        rdchk(0, 8'hFE & MMASK, "ctrl_readback");
        wr(0, 8'h00);
        wr(1, 8'h5C);
        rdchk(1, 8'h5C, "div_readback");
        wr(5, 8'hFF);
        rdchk(5, 8'h00, "reserved_read");
        rdchk(2, 8'h00, "txdata_read");
        wr(2, 8'hAA);
        rdchk(4, 8'h00, "en0_ignored");

        // Basic transfer, DIV=0
        wr(0, 8'h11); wr(1, 8'h00); miso_byte = 8'h3C;
        wr(2, 8'hA5);
        chk("cs_sel01", cs_n_o, 2'b10);
        repeat (20) @(negedge clk_i);
        chk("mosi_bits", mosi_cap, 8'hA5);
        chk("busy_len_div0", last_cs, 18);
        rdchk(4, 8'h02, "done_status");
        rdchk(3, 8'h3C, "rxdata_3c");
        rdchk(4, 8'h00, "done_cleared");

        // DIV=3
        wr(1, 8'h03); miso_byte = 8'hC3;
        wr(2, 8'h0F);
        repeat (75) @(negedge clk_i);
        chk("sclk_high_div3", last_hi, 4);
        chk("busy_len_div3", last_cs, 72);
        rdchk(3, 8'hC3, "rxdata_c3");

        // Overrun
        wr(1, 8'h00); miso_byte = 8'h81;
        wr(2, 8'h3C);
        wr(2, 8'h5A);
        rdchk(4, 8'h05, "ovr_busy");
        repeat (20) @(negedge clk_i);
        chk("ovr_mosi_kept", mosi_cap, 8'h3C);
        rdchk(3, 8'h81, "rxdata_81");
        rdchk(4, 8'h04, "ovr_sticky");
        wr(4, 8'h04);
        rdchk(4, 8'h00, "ovr_cleared");

        // Interrupt
        wr(0, 8'h19); miso_byte = 8'h66;
        wr(2, 8'h99);
        repeat (20) @(negedge clk_i);
        chk("inta_set", inta_o, 1);
        rdchk(3, 8'h66, "rxdata_66");
        chk("inta_cleared", inta_o, 0);

        // DONE set and STATUS clear on the same edge
        wr(0, 8'h11); miso_byte = 8'h24;
        wr(2, 8'h42);
        repeat (16) @(negedge clk_i);
        wr(4, 8'h02);
        rdchk(4, 8'h02, "done_set_wins");
        wr(4, 8'h02);
        rdchk(4, 8'h00, "done_w1c");

        // EN dropped mid-transfer
        miso_byte = 8'h5A;
        wr(2, 8'hF0);
        wr(0, 8'h10);
        repeat (20) @(negedge clk_i);
        rdchk(3, 8'h5A, "en_drop_rx");
        wr(2, 8'h11);
        chk("en0_no_cs", cs_n_o, 2'b11);
        rdchk(4, 8'h00, "en0_status");

        // No chip select
        wr(0, 8'h01); miso_byte = 8'h0E;
        wr(2, 8'h77);
        chk("cs_none", cs_n_o, 2'b11);
        repeat (20) @(negedge clk_i);
        rdchk(4, 8'h02, "cs_none_done");
        rdchk(3, 8'h0E, "cs_none_rx");

        // CPOL=1
        wr(0, 8'h13);
        chk("cpol_idle", sclk_o, 1);
        miso_byte = 8'hB2;
        wr(2, 8'hC5);
        repeat (20) @(negedge clk_i);
        rdchk(3, 8'hB2, "cpol_rx");
        wr(0, 8'h11);

        // Held strobe: ack alternates
        cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 3'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("held_ack", ack_o, (i % 2 == 0) ? 1 : 0);
        end
        cyc_i = 0; stb_i = 0;
        @(negedge clk_i);

        // DIV=0xFF
        wr(1, 8'hFF); miso_byte = 8'hE7;
        wr(2, 8'h18);
        repeat (18 * 256 + 5) @(negedge clk_i);
        chk("busy_len_divff", last_cs, 4608);
        rdchk(3, 8'hE7, "rxdata_e7");

`ifdef RFID_SPI_LOOPBACK_EN
        wr(1, 8'h00); wr(0, 8'h51); miso_byte = 8'h3C;
        wr(2, 8'h96);
        repeat (20) @(negedge clk_i);
        rdchk(3, 8'h96, "loopback_rx");
        rdchk(0, 8'h51, "loop_readback");
`endif

        // Reset mid-transfer
        wr(0, 8'h11); wr(1, 8'h03);
        wr(2, 8'hAB);
        repeat (10) @(negedge clk_i);
        #2 rst_i = 0;
        #1 chk("rst_mid_cs", cs_n_o, 2'b11);
        chk("rst_mid_sclk", sclk_o, 0);
        @(negedge clk_i);
        rst_i = 1;
        rdchk(4, 8'h00, "rst_mid_status");
        rdchk(0, 8'h00, "rst_mid_ctrl");
        chk("rst_mid_idle_cs", cs_n_o, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
